// File: rtl/sap_datapath_if.sv
// Controller and program-loader signals of the SAP-1 datapath, grouped as one bundle.
// master = microcode controller / loader side, slave = datapath side.
interface sap_datapath_if #(
    parameter int DATA_W = 8
);
    logic [15:0]       ctrl;
    logic              start;
    logic              prog_we;
    logic [3:0]        prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        opcode;
    logic              flag_c;
    logic              flag_z;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [DATA_W-1:0] dbg_bus;

    modport master (
        output ctrl, start, prog_we, prog_addr, prog_data,
        input  opcode, flag_c, flag_z, out_data, out_valid, halted, dbg_bus
    );

    modport slave (
        input  ctrl, start, prog_we, prog_addr, prog_data,
        output opcode, flag_c, flag_z, out_data, out_valid, halted, dbg_bus
    );
endinterface

// File: rtl/sap_datapath.sv
// SAP-1 datapath: registers, ALU, 16x8 RAM and shared bus; SAP_BUS_CONFLICT_CHECK_EN adds bus_err.
// Latency: register loads on the edge after ctrl is presented; out_valid one cycle after OUT loads.
// No backpressure: the controller owns sequencing; halted gates all ctrl bits.
module sap_datapath #(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    sap_datapath_if.slave dp
`ifdef SAP_BUS_CONFLICT_CHECK_EN
    ,
    output logic          bus_err
`endif
);
    localparam int AW = 4;

    logic [AW-1:0]     pc;
    logic [AW-1:0]     mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] out_reg;
    logic              flag_c_q;
    logic              flag_z_q;
    logic              out_valid_q;
    logic              halted_q;
    logic [DATA_W-1:0] ram [RAM_DEPTH];
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   alu;
    logic              alu_zero;

    logic fi, jmp, co, ce, oi, bi, su, eo, ai, ao, ii, io, ri, ro, mi, hlt;

    assign {fi, jmp, co, ce, oi, bi, su, eo, ai, ao, ii, io, ri, ro, mi, hlt} = dp.ctrl;

    // Subtract is A + ~B + 1, so carry out means A >= B.
    assign alu      = {1'b0, a} + {1'b0, (su ? ~b : b)} + {{DATA_W{1'b0}}, su};
    assign alu_zero = (alu[DATA_W-1:0] == '0);

    always_comb begin
        bus = '0;
        if (eo)      bus = alu[DATA_W-1:0];
        else if (ao) bus = a;
        else if (ro) bus = ram[mar];
        else if (io) bus = {{(DATA_W-AW){1'b0}}, ir[AW-1:0]};
        else if (co) bus = {{(DATA_W-AW){1'b0}}, pc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            mar         <= '0;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            out_reg     <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            if (halted_q) begin
                if (dp.start) halted_q <= 1'b0;
            end else begin
                if (mi) mar <= bus[AW-1:0];
                if (ii) ir  <= bus;
                if (ai) a   <= bus;
                if (bi) b   <= bus;
                if (oi) begin
                    out_reg     <= bus;
                    out_valid_q <= 1'b1;
                end
                if (jmp)     pc <= bus[AW-1:0];
                else if (ce) pc <= pc + 4'd1;
                if (fi) begin
                    flag_c_q <= alu[DATA_W];
                    flag_z_q <= alu_zero;
                end
                if (hlt) halted_q <= 1'b1;
            end
        end
    end

    // RAM is deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (halted_q) begin
            if (dp.prog_we) ram[dp.prog_addr] <= dp.prog_data;
        end else if (ri) begin
            ram[mar] <= bus;
        end
    end

    assign dp.opcode    = ir[DATA_W-1 -: AW];
    assign dp.flag_c    = flag_c_q;
    assign dp.flag_z    = flag_z_q;
    assign dp.out_data  = out_reg;
    assign dp.out_valid = out_valid_q;
    assign dp.halted    = halted_q;
    assign dp.dbg_bus   = bus;

`ifdef SAP_BUS_CONFLICT_CHECK_EN
    logic multi_drv;
    assign multi_drv = ($countones({eo, ao, ro, io, co}) > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         bus_err <= 1'b0;
        else if (!halted_q && multi_drv) bus_err <= 1'b1;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !halted_q && multi_drv)
            $display("sap_datapath: bus conflict, ctrl=%h", dp.ctrl);
    end
`endif
`endif
endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: drives SAP-1 microcode, scoreboards OUT values against an instruction-level model.
module tb_sap_datapath;
    localparam logic [15:0] FI = 16'h8000, JP = 16'h4000, CO = 16'h2000, CE = 16'h1000;
    localparam logic [15:0] OI = 16'h0800, BI = 16'h0400, SU = 16'h0200, EO = 16'h0100;
    localparam logic [15:0] AI = 16'h0080, AO = 16'h0040, II = 16'h0020, IO = 16'h0010;
    localparam logic [15:0] RI = 16'h0008, RO = 16'h0004, MI = 16'h0002, HLT = 16'h0001;

    logic clk = 1'b0;
    logic rst;
`ifdef SAP_BUS_CONFLICT_CHECK_EN
    logic bus_err;
`endif

    sap_datapath_if #(.DATA_W(8)) dp ();

    sap_datapath #(.RAM_DEPTH(16), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .dp      (dp)
`ifdef SAP_BUS_CONFLICT_CHECK_EN
        ,
        .bus_err (bus_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int vld_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] img [16];
    // Architectural model state: accumulator and flags as a program would see them.
    logic [7:0] ma = 8'h00;
    logic       mc = 1'b0;
    logic       mz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dp.out_valid === 1'b1) begin
            vld_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got %0h expected no output", dp.out_data);
            end else begin
                chk("out_data", {24'h0, dp.out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycle(input logic [15:0] c);
        @(negedge clk);
        dp.ctrl    = c;
        dp.start   = 1'b0;
        dp.prog_we = 1'b0;
    endtask

    task automatic peek(input logic [15:0] c, output logic [7:0] v);
        cycle(c);
        #1 v = dp.dbg_bus;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        dp.ctrl    = 16'h0;
        dp.prog_we = 1'b0;
        dp.start   = 1'b1;
    endtask

    task automatic set_pc(input int n);
        cycle(JP);
        for (int i = 0; i < n; i++) cycle(CE);
    endtask

    task automatic ram_peek(input int adr, output logic [7:0] v);
        set_pc(adr);
        cycle(CO | MI);
        peek(RO, v);
    endtask

    // Writes the whole image; start rides on the final write.
    task automatic load_image();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            dp.ctrl      = 16'h0;
            dp.prog_we   = 1'b1;
            dp.prog_addr = 4'(i);
            dp.prog_data = img[i];
            dp.start     = (i == 15);
        end
    endtask

    task automatic fetch(input logic [3:0] exp_op);
        cycle(CO | MI);
        cycle(RO | II | CE);
        @(posedge clk);
        #1 chk("opcode", {28'h0, dp.opcode}, {28'h0, exp_op});
    endtask

    task automatic run_program();
        logic [7:0] mram [16];
        logic [7:0] ins;
        logic [7:0] m;
        logic [8:0] s;
        int         pc;
        bit         done;
        foreach (img[i]) mram[i] = img[i];
        load_image();
        cycle(JP);
        pc   = 0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            ins = mram[pc];
            m   = mram[ins[3:0]];
            fetch(ins[7:4]);
            pc = (pc + 1) % 16;
            case (ins[7:4])
                4'h1: begin
                    cycle(MI | IO); cycle(RO | AI);
                    ma = m;
                end
                4'h2: begin
                    cycle(MI | IO); cycle(RO | BI); cycle(EO | AI | FI);
                    s  = {1'b0, ma} + {1'b0, m};
                    mc = s[8];
                    ma = s[7:0];
                    mz = (ma == 8'h00);
                end
                4'h3: begin
                    cycle(MI | IO); cycle(RO | BI); cycle(EO | AI | FI | SU);
                    mc = (ma >= m);
                    ma = ma - m;
                    mz = (ma == 8'h00);
                end
                4'h4: begin
                    cycle(MI | IO); cycle(AO | RI);
                    mram[ins[3:0]] = ma;
                end
                4'hE: begin
                    exp_q.push_back(ma);
                    cycle(AO | OI);
                end
                4'hF: begin
                    cycle(HLT);
                    done = 1'b1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("halted_end", {31'h0, dp.halted}, 32'h1);
        chk("flag_c", {31'h0, dp.flag_c}, {31'h0, mc});
        chk("flag_z", {31'h0, dp.flag_z}, {31'h0, mz});
    endtask

    task automatic plan_image(input logic [7:0] op2, input logic [7:0] d14, input logic [7:0] d15);
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h1E; img[1] = op2; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = d14;  img[15] = d15;
    endtask

    initial begin
        logic [7:0] v;
        int         v0;
        int         len;
        logic [3:0] op;

        rst          = 1'b1;
        dp.ctrl      = 16'h0;
        dp.start     = 1'b0;
        dp.prog_we   = 1'b0;
        dp.prog_addr = 4'h0;
        dp.prog_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_halted", {31'h0, dp.halted}, 32'h1);
        chk("rst_out_data", {24'h0, dp.out_data}, 32'h0);
        chk("rst_out_valid", {31'h0, dp.out_valid}, 32'h0);
        chk("rst_flags", {30'h0, dp.flag_c, dp.flag_z}, 32'h0);
        chk("rst_opcode", {28'h0, dp.opcode}, 32'h0);
        chk("idle_bus", {24'h0, dp.dbg_bus}, 32'h0);
`ifdef SAP_BUS_CONFLICT_CHECK_EN
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // LDA 14 / ADD 15 / OUT / HLT with 5 + 3.
        plan_image(8'h2F, 8'h05, 8'h03);
        v0 = vld_seen;
        run_program();
        chk("tp_out", {24'h0, dp.out_data}, 32'h08);
        chk("tp_vld_pulses", vld_seen - v0, 1);

        plan_image(8'h3F, 8'h03, 8'h03);
        run_program();
        chk("sub_eq_out", {24'h0, dp.out_data}, 32'h00);
        chk("sub_eq_cz", {30'h0, dp.flag_c, dp.flag_z}, 32'h3);
        plan_image(8'h3F, 8'h02, 8'h03);
        run_program();
        chk("sub_lt_out", {24'h0, dp.out_data}, 32'hFF);
        chk("sub_lt_cz", {30'h0, dp.flag_c, dp.flag_z}, 32'h0);

        // PC wrap and jump-over-increment.
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'h6F; img[1] = 8'h67; img[5] = 8'h5A;
        load_image();
        cycle(MI);
        cycle(RO | II);
        peek(IO | JP, v);
        chk("io_bus", {24'h0, v}, 32'h0F);
        peek(CO, v);
        chk("pc_jump15", {24'h0, v}, 32'h0F);
        cycle(CE);
        peek(CO, v);
        chk("pc_wrap", {24'h0, v}, 32'h00);
        cycle(CE);
        cycle(CO | MI);
        cycle(RO | II);
        @(posedge clk);
        #1 chk("ir_opcode", {28'h0, dp.opcode}, 32'h6);
        peek(CE | JP | IO, v);
        chk("io_bus_67", {24'h0, v}, 32'h07);
        peek(CO, v);
        chk("pc_j_over_ce", {24'h0, v}, 32'h07);

        // Halted gating, start keeps PC, prog_we ignored while running.
        peek(AO, v);
        chk("a_before_halt", {24'h0, v}, {24'h0, ma});
        cycle(HLT);
        cycle(AI | CO);
        cycle(CE | JP);
        #1 chk("still_halted", {31'h0, dp.halted}, 32'h1);
        start_pulse();
        peek(CO, v);
        chk("halt_pc_kept", {24'h0, v}, 32'h07);
        peek(AO, v);
        chk("halt_a_kept", {24'h0, v}, {24'h0, ma});
        @(negedge clk);
        dp.ctrl = 16'h0; dp.prog_we = 1'b1; dp.prog_addr = 4'd5; dp.prog_data = 8'hAA;
        ram_peek(5, v);
        chk("run_prog_we_ignored", {24'h0, v}, 32'h5A);

        // Two drivers: A wins over RAM.
        peek(AO | RO, v);
        chk("conflict_bus", {24'h0, v}, {24'h0, ma});
`ifdef SAP_BUS_CONFLICT_CHECK_EN
        @(posedge clk);
        #1 chk("bus_err_set", {31'h0, bus_err}, 32'h1);
        repeat (3) cycle(16'h0);
        #1 chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);
`endif
        cycle(HLT);

        // Async reset during the ADD execute step.
        plan_image(8'h2F, 8'h05, 8'h03);
        load_image();
        cycle(JP);
        fetch(4'h1);
        cycle(MI | IO); cycle(RO | AI);
        fetch(4'h2);
        cycle(MI | IO); cycle(RO | BI);
        cycle(EO | AI | FI);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_halted", {31'h0, dp.halted}, 32'h1);
        chk("mid_rst_out", {24'h0, dp.out_data}, 32'h0);
        chk("mid_rst_opcode", {28'h0, dp.opcode}, 32'h0);
        chk("mid_rst_flags", {30'h0, dp.flag_c, dp.flag_z}, 32'h0);
`ifdef SAP_BUS_CONFLICT_CHECK_EN
        chk("mid_rst_bus_err", {31'h0, bus_err}, 32'h0);
`endif
        ma = 8'h00; mc = 1'b0; mz = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        dp.ctrl = 16'h0;
        start_pulse();
        peek(AO, v);
        chk("rst_a", {24'h0, v}, 32'h00);
        peek(CO, v);
        chk("rst_pc", {24'h0, v}, 32'h00);
        peek(IO, v);
        chk("rst_ir", {24'h0, v}, 32'h00);
        ram_peek(14, v);
        chk("ram_kept_14", {24'h0, v}, 32'h05);
        ram_peek(15, v);
        chk("ram_kept_15", {24'h0, v}, 32'h03);
        cycle(HLT);

        // Random straight-line programs.
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(2, 7);
            for (int i = 0; i < 16; i++)
                img[i] = (i < 8) ? 8'h00 :
                         (($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
            for (int i = 0; i < len - 1; i++) begin
                case ($urandom_range(0, 4))
                    0:       op = 4'h1;
                    1:       op = 4'h2;
                    2:       op = 4'h3;
                    3:       op = 4'h4;
                    default: op = 4'hE;
                endcase
                img[i] = {op, 4'($urandom_range(8, 15))};
            end
            img[len - 1] = 8'hE0;
            img[len]     = 8'hF0;
            run_program();
        end

        repeat (4) cycle(16'h0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- 8-bit SAP-1 datapath that consumes the 16-bit control word from the microcode controller.
- Contains the following state:
  - PC (4b), MAR (4b), IR (8b), A (8b), B (8b), OUT (8b)
  - adder/subtractor
  - carry/zero flags
  - 16x8 RAM
  - a single shared 8-bit bus
- Returns the opcode and flags to the controller.
- Provides a program-load port for filling RAM while the machine is halted.

Parameters:
- RAM_DEPTH, 16, number of RAM words; address width is fixed at 4.
- DATA_W, 8, bus/register width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ctrl  in  16  control word. Bit assignment:
  - 15 FI flags-in
  - 14 J jump
  - 13 CO PC-out
  - 12 CE PC-increment
  - 11 OI out-in
  - 10 BI B-in
  - 9 SU subtract
  - 8 EO ALU-out
  - 7 AI A-in
  - 6 AO A-out
  - 5 II IR-in
  - 4 IO IR-out
  - 3 RI RAM-in
  - 2 RO RAM-out
  - 1 MI MAR-in
  - 0 HLT halt
- start  in  1  one-cycle pulse that clears halted.
- prog_we  in  1  RAM program write strobe.
- prog_addr  in  4  RAM program address.
- prog_data  in  8  RAM program data.
- opcode  out  4  IR[7:4].
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- out_data  out  8  OUT register.
- out_valid  out  1  one-cycle pulse the cycle after OUT loads.
- halted  out  1  machine halted.
- dbg_bus  out  8  current bus value.

Behaviour:
- Reset (async, rst=1):
  - PC, MAR, IR, A, B, OUT = 0; flag_c, flag_z = 0; out_valid = 0; halted = 1.
  - RAM contents are not reset.
  - Reset mid-instruction discards all partial state.
- Bus is combinational from the drive bits, with fixed priority when several are set: EO > AO > RO > IO > CO.
  - EO drives alu_sum; AO drives A; RO drives RAM[MAR]; IO drives {4'h0, IR[3:0]}; CO drives {4'h0, PC}.
  - No driver drives 8'h00.
- ALU (combinational, 9-bit): {c, sum} = A + (SU ? ~B : B) + SU.
  - Subtraction therefore gives c=1 when A >= B.
  - zero = (sum == 0).
- Rising edge when halted == 0:
  - MI: MAR <= bus[3:0].
  - RI: RAM[MAR] <= bus.
  - II: IR <= bus.
  - AI: A <= bus.
  - BI: B <= bus.
  - OI: OUT <= bus; out_valid <= 1 on the next cycle, otherwise 0.
  - CE: PC <= PC + 1, wrapping 15 -> 0.
  - J: PC <= bus[3:0]. J has priority over CE when both are set.
  - FI: flag_c <= c; flag_z <= zero. Flags are held when FI=0.
  - HLT: halted <= 1. All other bits in the same control word still take effect in that cycle; all ctrl bits are ignored from the next cycle.
- Simultaneous source and sink: loads use the pre-edge bus value.
  - AO+AI leaves A unchanged.
  - RO+RI rewrites RAM with its old value.
  - EO+AI loads A with the ALU result computed from the old A.
- While halted == 1:
  - All ctrl bits are ignored.
  - prog_we writes RAM[prog_addr] <= prog_data.
  - start clears halted on the next edge; PC is unchanged.
- prog_we while halted == 0 is ignored.
- start while halted == 0 is ignored.
- start and prog_we in the same cycle: the write happens, then the machine runs.
- Outputs:
  - opcode, flags, out_data and halted are registered values.
  - dbg_bus is combinational.

Optional Feature:
- Macro: SAP_BUS_CONFLICT_CHECK_EN.
- With the macro defined:
  - Adds output bus_err (1b), sticky, cleared only by rst.
  - bus_err is set on any rising edge where more than one of EO/AO/RO/IO/CO is asserted while halted == 0.
  - Simulation builds also print the offending ctrl value.
- Without the macro: no bus_err port and no checking logic; priority resolution is unchanged.

Test Plan:
- Reset then load: load RAM[0..3] = 8'h1E, 8'h2F, 8'hE0, 8'hF0 and RAM[14] = 8'h05, RAM[15] = 8'h03 via prog_we; pulse start; drive the LDA 14 / ADD 15 / OUT / HLT microcode -> out_data = 8'h08, out_valid pulses once, flag_c = 0, flag_z = 0, halted = 1.
- Subtract: A = 8'h03, B = 8'h03, ctrl SU|EO|AI|FI -> A = 8'h00, flag_z = 1, flag_c = 1. Then A = 8'h02, B = 8'h03 -> A = 8'hFF, flag_c = 0, flag_z = 0.
- PC behaviour: PC = 15 with CE -> PC = 0. CE|J with bus = 8'h07 (IO, IR = 8'h67) -> PC = 7.
- Halted gating: with halted = 1, drive AI|CO -> A and PC unchanged. prog_we with halted = 0, addr 5, data 8'hAA -> RAM[5] unchanged.
- Async reset mid-run: assert rst between clock edges during the ADD execute step -> all registers 0 and halted = 1 immediately; RAM contents retained.
- With SAP_BUS_CONFLICT_CHECK_EN: drive AO|RO -> bus = A, bus_err = 1 and stays set until rst. Without the macro, the same stimulus gives bus = A and no error port.
